// File: rtl/trigger_capture_ctrl.sv
// Capture sequencer: arms on a bus strobe, frames one acquisition out of the
// event-tagged sample stream and forwards it through a single output slice.
module trigger_capture_ctrl #(
    parameter int unsigned BDW = 32,
    parameter int unsigned BAW = 2,
    parameter int unsigned SDW = 32,
    parameter int unsigned CCW = 32
) (
    input  logic           clk,
    input  logic           rst,
    output logic           bus_wready,
    input  logic           bus_wvalid,
    input  logic [BAW-1:0] bus_waddr,
    input  logic [BDW-1:0] bus_wdata,
    output logic           sti_tready,
    input  logic           sti_tvalid,
    input  logic [1:0]     sti_tevent,
    input  logic [SDW-1:0] sti_tdata,
    input  logic           sto_tready,
    output logic           sto_tvalid,
    output logic           sto_tlast,
    output logic [SDW-1:0] sto_tdata,
    output logic [2:0]     sts_state,
    output logic [CCW-1:0] sts_tpos,
    output logic           sts_abort
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARMED = 3'd1;
    localparam logic [2:0] ST_PRE   = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_POST  = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    localparam logic [1:0] EV_START = 2'b01;
    localparam logic [1:0] EV_TRIG  = 2'b10;
    localparam logic [1:0] EV_ABORT = 2'b11;

    localparam logic [BAW-1:0] ADDR_CTRL = BAW'(0);
    localparam logic [BAW-1:0] ADDR_PRE  = BAW'(1);
    localparam logic [BAW-1:0] ADDR_POST = BAW'(2);

    logic [2:0]     state_q;
    logic [2:0]     state_d;
    logic [CCW-1:0] cfg_pre;
    logic [CCW-1:0] cfg_post;
    logic [CCW-1:0] beat_cnt;
    logic [CCW-1:0] post_cnt;

    logic           fwd_state;
    logic           idle_or_done;
    logic           accept;
    logic           bus_arm;
    logic           bus_abort;
    logic [CCW-1:0] eff_pre;
    logic [CCW-1:0] eff_post;
    logic [CCW-1:0] beat_next;
    logic [CCW-1:0] post_next;

    logic           load;
    logic           load_last;
    logic           beat_start;
    logic           beat_step;
    logic           post_start;
    logic           post_step;
    logic           tpos_load;
    logic           abort_set;
    logic           arm_clr;

    assign bus_wready   = 1'b1;
    assign sts_state    = state_q;
    assign fwd_state    = (state_q == ST_PRE) || (state_q == ST_WAIT) || (state_q == ST_POST);
    assign idle_or_done = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign sti_tready   = fwd_state ? (!sto_tvalid || sto_tready) : 1'b1;
    assign accept       = sti_tvalid && sti_tready;
    assign bus_arm      = bus_wvalid && (bus_waddr == ADDR_CTRL) && bus_wdata[0];
    assign bus_abort    = bus_wvalid && (bus_waddr == ADDR_CTRL) && bus_wdata[1];

    // Zero-length settings behave as one beat.
    assign eff_pre   = (cfg_pre == '0)  ? CCW'(1) : cfg_pre;
    assign eff_post  = (cfg_post == '0) ? CCW'(1) : cfg_post;
    assign beat_next = (beat_cnt == '1) ? beat_cnt : beat_cnt + CCW'(1);
    assign post_next = post_cnt + CCW'(1);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next state and per-beat control; the concurrent sample follows the
    // current state, the bus command then overrides the next state.
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        load_last  = 1'b0;
        beat_start = 1'b0;
        beat_step  = 1'b0;
        post_start = 1'b0;
        post_step  = 1'b0;
        tpos_load  = 1'b0;
        abort_set  = 1'b0;
        arm_clr    = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: ;
            ST_ARMED: begin
                if (accept && sti_tevent == EV_START) begin
                    load       = 1'b1;
                    beat_start = 1'b1;
                    state_d    = (eff_pre > CCW'(1)) ? ST_PRE : ST_WAIT;
                end else if (accept && sti_tevent == EV_ABORT) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (accept) begin
                    load      = 1'b1;
                    beat_step = 1'b1;
                    if (sti_tevent == EV_ABORT) begin
                        load_last = 1'b1;
                        abort_set = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (beat_next >= eff_pre) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (accept) begin
                    load      = 1'b1;
                    beat_step = 1'b1;
                    if (sti_tevent == EV_ABORT) begin
                        load_last = 1'b1;
                        abort_set = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (sti_tevent == EV_TRIG) begin
                        tpos_load  = 1'b1;
                        post_start = 1'b1;
                        if (eff_post > CCW'(1)) begin
                            state_d = ST_POST;
                        end else begin
                            load_last = 1'b1;
                            state_d   = ST_DONE;
                        end
                    end
                end
            end
            ST_POST: begin
                if (accept) begin
                    load      = 1'b1;
                    post_step = 1'b1;
                    if (sti_tevent == EV_ABORT) begin
                        load_last = 1'b1;
                        abort_set = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (post_next >= eff_post) begin
                        load_last = 1'b1;
                        state_d   = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bus_abort) begin
            state_d = ST_IDLE;
            if (!idle_or_done) abort_set = 1'b1;
        end else if (bus_arm && idle_or_done) begin
            state_d = ST_ARMED;
            arm_clr = 1'b1;
        end
    end

    // Output register slice.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sto_tvalid <= 1'b0;
            sto_tlast  <= 1'b0;
            sto_tdata  <= '0;
        end else if (load) begin
            sto_tvalid <= 1'b1;
            sto_tlast  <= load_last;
            sto_tdata  <= sti_tdata;
        end else if (sto_tready) begin
            sto_tvalid <= 1'b0;
            sto_tlast  <= 1'b0;
        end
    end

    // Configuration registers, writable only between acquisitions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_pre  <= '0;
            cfg_post <= '0;
        end else if (bus_wvalid && idle_or_done) begin
            if (bus_waddr == ADDR_PRE)  cfg_pre  <= bus_wdata[CCW-1:0];
            if (bus_waddr == ADDR_POST) cfg_post <= bus_wdata[CCW-1:0];
        end
    end

    // Beat counters and status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt  <= '0;
            post_cnt  <= '0;
            sts_tpos  <= '0;
            sts_abort <= 1'b0;
        end else begin
            if (arm_clr)         beat_cnt <= '0;
            else if (beat_start) beat_cnt <= CCW'(1);
            else if (beat_step)  beat_cnt <= beat_next;

            if (post_start)     post_cnt <= CCW'(1);
            else if (post_step) post_cnt <= post_next;

            if (arm_clr)        sts_tpos <= '0;
            else if (tpos_load) sts_tpos <= beat_cnt;

            if (abort_set)    sts_abort <= 1'b1;
            else if (arm_clr) sts_abort <= 1'b0;
        end
    end

endmodule

// File: tb/tb_trigger_capture_ctrl.sv
// Directed vector bench for trigger_capture_ctrl: a per-cycle stimulus/expect
// table plus hand-written sequences for reset behaviour.
module tb_trigger_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_wready;
    logic        bus_wvalid;
    logic [1:0]  bus_waddr;
    logic [31:0] bus_wdata;
    logic        sti_tready;
    logic        sti_tvalid;
    logic [1:0]  sti_tevent;
    logic [31:0] sti_tdata;
    logic        sto_tready;
    logic        sto_tvalid;
    logic        sto_tlast;
    logic [31:0] sto_tdata;
    logic [2:0]  sts_state;
    logic [31:0] sts_tpos;
    logic        sts_abort;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    trigger_capture_ctrl #(.BDW(32), .BAW(2), .SDW(32), .CCW(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_wready (bus_wready),
        .bus_wvalid (bus_wvalid),
        .bus_waddr  (bus_waddr),
        .bus_wdata  (bus_wdata),
        .sti_tready (sti_tready),
        .sti_tvalid (sti_tvalid),
        .sti_tevent (sti_tevent),
        .sti_tdata  (sti_tdata),
        .sto_tready (sto_tready),
        .sto_tvalid (sto_tvalid),
        .sto_tlast  (sto_tlast),
        .sto_tdata  (sto_tdata),
        .sts_state  (sts_state),
        .sts_tpos   (sts_tpos),
        .sts_abort  (sts_abort)
    );

    typedef struct {
        logic        bw;
        logic [1:0]  ba;
        logic [31:0] bd;
        logic        sv;
        logic [1:0]  ev;
        logic [31:0] sd;
        logic        rdy;
        logic        e_trdy;
        logic        e_v;
        logic        e_l;
        logic [31:0] e_d;
        logic [2:0]  e_st;
        logic [31:0] e_tpos;
        logic        e_ab;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int bw, int ba, int bd, int sv, int ev, int sd, int rdy,
                                int etr, int ev_, int el, int ed, int est, int etp, int eab);
        vec_t r;
        r.bw = 1'(bw);   r.ba = 2'(ba);   r.bd = 32'(bd);
        r.sv = 1'(sv);   r.ev = 2'(ev);   r.sd = 32'(sd);  r.rdy = 1'(rdy);
        r.e_trdy = 1'(etr); r.e_v = 1'(ev_); r.e_l = 1'(el); r.e_d = 32'(ed);
        r.e_st = 3'(est);   r.e_tpos = 32'(etp); r.e_ab = 1'(eab);
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic bw, input logic [1:0] ba, input logic [31:0] bd,
                         input logic sv, input logic [1:0] ev, input logic [31:0] sd,
                         input logic rdy);
        bus_wvalid = bw; bus_waddr = ba; bus_wdata = bd;
        sti_tvalid = sv; sti_tevent = ev; sti_tdata = sd; sto_tready = rdy;
    endtask

    // One cycle: drive at negedge, then sample #1 after the active edge.
    task automatic cyc(input logic bw, input logic [1:0] ba, input logic [31:0] bd,
                       input logic sv, input logic [1:0] ev, input logic [31:0] sd,
                       input logic rdy);
        @(negedge clk);
        drive(bw, ba, bd, sv, ev, sd, rdy);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0, 1'b1);

        // Basic capture: PRE=3, POST=2, five leading samples dropped.
        vecs.push_back(mk(1,1,3,     0,0,0,     1, 1,0,0,0,     0,0,0));
        vecs.push_back(mk(1,2,2,     0,0,0,     1, 1,0,0,0,     0,0,0));
        vecs.push_back(mk(1,0,1,     0,0,0,     1, 1,0,0,0,     1,0,0));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,0, 1,0,'hA0+i, 1, 1,0,0,0,     1,0,0));
        vecs.push_back(mk(0,0,0,     1,1,'hB0,  1, 1,1,0,'hB0,  2,0,0));
        vecs.push_back(mk(0,0,0,     1,0,'hB1,  1, 1,1,0,'hB1,  2,0,0));
        vecs.push_back(mk(0,0,0,     1,2,'hB2,  1, 1,1,0,'hB2,  3,0,0));
        vecs.push_back(mk(0,0,0,     1,0,'hB3,  1, 1,1,0,'hB3,  3,0,0));
        vecs.push_back(mk(0,0,0,     1,0,'hB4,  1, 1,1,0,'hB4,  3,0,0));
        vecs.push_back(mk(0,0,0,     1,2,'hB5,  1, 1,1,0,'hB5,  4,5,0));
        vecs.push_back(mk(0,0,0,     1,0,'hB6,  1, 1,1,1,'hB6,  5,5,0));
        vecs.push_back(mk(0,0,0,     0,0,0,     1, 1,0,0,0,     5,5,0));
        // Early trigger ignored: PRE=4, POST=3.
        vecs.push_back(mk(1,1,4,     0,0,0,     1, 1,0,0,0,     5,5,0));
        vecs.push_back(mk(1,2,3,     0,0,0,     1, 1,0,0,0,     5,5,0));
        vecs.push_back(mk(1,0,1,     0,0,0,     1, 1,0,0,0,     1,0,0));
        vecs.push_back(mk(0,0,0,     1,1,'hC0,  1, 1,1,0,'hC0,  2,0,0));
        vecs.push_back(mk(0,0,0,     1,2,'hC1,  1, 1,1,0,'hC1,  2,0,0));
        vecs.push_back(mk(0,0,0,     1,0,'hC2,  1, 1,1,0,'hC2,  2,0,0));
        vecs.push_back(mk(0,0,0,     1,0,'hC3,  1, 1,1,0,'hC3,  3,0,0));
        vecs.push_back(mk(0,0,0,     1,2,'hC4,  1, 1,1,0,'hC4,  4,4,0));
        vecs.push_back(mk(0,0,0,     1,0,'hC5,  1, 1,1,0,'hC5,  4,4,0));
        vecs.push_back(mk(0,0,0,     1,0,'hC6,  1, 1,1,1,'hC6,  5,4,0));
        // Backpressure in WAIT, then abort tag: PRE=1.
        vecs.push_back(mk(1,1,1,     0,0,0,     1, 1,0,0,0,     5,4,0));
        vecs.push_back(mk(1,0,1,     0,0,0,     1, 1,0,0,0,     1,0,0));
        vecs.push_back(mk(0,0,0,     1,1,'hD0,  1, 1,1,0,'hD0,  3,0,0));
        vecs.push_back(mk(0,0,0,     1,0,'hD1,  1, 1,1,0,'hD1,  3,0,0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,0,0, 1,0,'hD2,  0, 0,1,0,'hD1,  3,0,0));
        vecs.push_back(mk(0,0,0,     1,0,'hD2,  1, 1,1,0,'hD2,  3,0,0));
        vecs.push_back(mk(0,0,0,     1,3,'hD3,  1, 1,1,1,'hD3,  0,0,1));
        vecs.push_back(mk(0,0,0,     0,0,0,     1, 1,0,0,0,     0,0,1));
        // Bus ABORT while a beat is stalled in the slice.
        vecs.push_back(mk(1,0,1,     0,0,0,     1, 1,0,0,0,     1,0,0));
        vecs.push_back(mk(0,0,0,     1,1,'hE0,  1, 1,1,0,'hE0,  3,0,0));
        vecs.push_back(mk(1,0,2,     0,0,0,     0, 0,1,0,'hE0,  0,0,1));
        vecs.push_back(mk(0,0,0,     0,0,0,     0, 1,1,0,'hE0,  0,0,1));
        vecs.push_back(mk(0,0,0,     0,0,0,     1, 1,0,0,0,     0,0,1));
        // PRE=0, POST=0, ARM during WAIT ignored, then ARM+ABORT together.
        vecs.push_back(mk(1,1,0,     0,0,0,     1, 1,0,0,0,     0,0,1));
        vecs.push_back(mk(1,2,0,     0,0,0,     1, 1,0,0,0,     0,0,1));
        vecs.push_back(mk(1,0,1,     0,0,0,     1, 1,0,0,0,     1,0,0));
        vecs.push_back(mk(0,0,0,     1,1,'hF0,  1, 1,1,0,'hF0,  3,0,0));
        vecs.push_back(mk(1,0,1,     1,0,'hF1,  1, 1,1,0,'hF1,  3,0,0));
        vecs.push_back(mk(0,0,0,     1,2,'hF2,  1, 1,1,1,'hF2,  5,2,0));
        vecs.push_back(mk(0,0,0,     0,0,0,     1, 1,0,0,0,     5,2,0));
        vecs.push_back(mk(1,0,1,     0,0,0,     1, 1,0,0,0,     1,0,0));
        vecs.push_back(mk(0,0,0,     1,1,'hA5,  1, 1,1,0,'hA5,  3,0,0));
        vecs.push_back(mk(1,0,3,     0,0,0,     1, 1,0,0,0,     0,0,1));

        repeat (3) @(negedge clk);
        chk("rst_tvalid", 32'(sto_tvalid), 32'd0);
        chk("rst_tlast",  32'(sto_tlast),  32'd0);
        chk("rst_tdata",  sto_tdata,       32'd0);
        chk("rst_state",  32'(sts_state),  32'd0);
        chk("rst_tpos",   sts_tpos,        32'd0);
        chk("rst_abort",  32'(sts_abort),  32'd0);
        chk("rst_wready", 32'(bus_wready), 32'd1);
        chk("rst_tready", 32'(sti_tready), 32'd1);
        rst = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].bw, vecs[i].ba, vecs[i].bd, vecs[i].sv, vecs[i].ev,
                  vecs[i].sd, vecs[i].rdy);
            #1;
            chk($sformatf("row%0d tready", i), 32'(sti_tready), 32'(vecs[i].e_trdy));
            @(posedge clk);
            #1;
            chk($sformatf("row%0d tvalid", i), 32'(sto_tvalid), 32'(vecs[i].e_v));
            chk($sformatf("row%0d tlast", i),  32'(sto_tlast),  32'(vecs[i].e_l));
            if (vecs[i].e_v)
                chk($sformatf("row%0d tdata", i), sto_tdata, vecs[i].e_d);
            chk($sformatf("row%0d state", i),  32'(sts_state),  32'(vecs[i].e_st));
            chk($sformatf("row%0d tpos", i),   sts_tpos,        vecs[i].e_tpos);
            chk($sformatf("row%0d abort", i),  32'(sts_abort),  32'(vecs[i].e_ab));
        end

        // Reset asserted in POST with a stalled beat clears everything at once.
        cyc(1'b1, 2'd1, 32'd1, 1'b0, 2'd0, 32'd0, 1'b1);
        cyc(1'b1, 2'd2, 32'd3, 1'b0, 2'd0, 32'd0, 1'b1);
        cyc(1'b1, 2'd0, 32'd1, 1'b0, 2'd0, 32'd0, 1'b1);
        cyc(1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 32'h90, 1'b1);
        cyc(1'b0, 2'd0, 32'd0, 1'b1, 2'd2, 32'h91, 1'b1);
        cyc(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0, 1'b0);
        chk("pre_rst_state",  32'(sts_state),  32'd4);
        chk("pre_rst_tvalid", 32'(sto_tvalid), 32'd1);
        chk("pre_rst_tdata",  sto_tdata,       32'h91);
        chk("pre_rst_tpos",   sts_tpos,        32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_tvalid", 32'(sto_tvalid), 32'd0);
        chk("mid_rst_tlast",  32'(sto_tlast),  32'd0);
        chk("mid_rst_tdata",  sto_tdata,       32'd0);
        chk("mid_rst_state",  32'(sts_state),  32'd0);
        chk("mid_rst_tpos",   sts_tpos,        32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 2'd0, 32'd0, 1'b0, 2'd0, 32'd0, 1'b1);

        // Configuration was cleared too: one-beat pre and post windows.
        cyc(1'b1, 2'd0, 32'd1, 1'b0, 2'd0, 32'd0, 1'b1);
        chk("post_rst_armed", 32'(sts_state), 32'd1);
        cyc(1'b0, 2'd0, 32'd0, 1'b1, 2'd1, 32'h80, 1'b1);
        chk("post_rst_wait",  32'(sts_state), 32'd3);
        cyc(1'b0, 2'd0, 32'd0, 1'b1, 2'd2, 32'h81, 1'b1);
        chk("post_rst_done",  32'(sts_state), 32'd5);
        chk("post_rst_tlast", 32'(sto_tlast), 32'd1);
        chk("post_rst_tdata", sto_tdata,      32'h81);
        chk("post_rst_tpos",  sts_tpos,       32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
